// File: rtl/fifo8x16.sv
// rtl/fifo8x16.sv - 8-entry x 16-bit first-word-fall-through FIFO with overflow/underflow pulses
module fifo8x16 (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        push,
  input  logic        pop,
  output logic [15:0] out,
  output logic        empty,
  output logic        full,
  output logic [3:0]  count,
  output logic        ovf,
  output logic        unf
);

  logic [15:0] mem [8];
  logic [2:0]  wp;
  logic [2:0]  rp;
  logic [7:0]  we;
  logic        push_ok;
  logic        pop_ok;

  assign empty = (count == 4'd0);
  assign full  = (count == 4'd8);
  assign out   = empty ? 16'h0000 : mem[rp];

  // A push into a full FIFO is taken only when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  for (genvar i = 0; i < 8; i++) begin : g_store
    assign we[i] = push_ok && (wp == 3'(i));

    always_ff @(posedge clock) begin
      if (!reset && we[i]) begin
        mem[i] <= in;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp    <= 3'd0;
      rp    <= 3'd0;
      count <= 4'd0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ovf <= push && !push_ok;
      unf <= pop && !pop_ok;
      if (push_ok) begin
        wp <= wp + 3'd1;
      end
      if (pop_ok) begin
        rp <= rp + 3'd1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 4'd1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 4'd1;
      end
    end
  end

endmodule
